// File: rtl/hazard_stall_sequencer_if.sv
// Decode/execute hazard handshake bundle: detector request, decode stage inputs,
// execute stage register outputs, ack/stall status and the bubble perf counter.
interface hazard_stall_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             hzd_req;
    logic             flush;
    logic [XLEN-1:0]  dec_ir;
    logic [XLEN-1:0]  dec_pc;
    logic             dec_valid;
    logic             hzd_ack;
    logic             stall_active;
    logic [XLEN-1:0]  ex_ir;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_valid;
    logic [CNT_W-1:0] stall_cycles_tot;
    logic [1:0]       dbg_state;

    // Handshake: the detector holds hzd_req high while a hazard is pending; the
    // sequencer answers with a single-cycle hzd_ack, on which the detector drops hzd_req.
    modport master (
        output hzd_req, flush, dec_ir, dec_pc, dec_valid,
        input  hzd_ack, stall_active, ex_ir, ex_pc, ex_valid, stall_cycles_tot, dbg_state
    );

    modport slave (
        input  hzd_req, flush, dec_ir, dec_pc, dec_valid,
        output hzd_ack, stall_active, ex_ir, ex_pc, ex_valid, stall_cycles_tot, dbg_state
    );
endinterface

// File: rtl/hazard_stall_sequencer.sv
// Owns the decode->execute pipeline register; injects STALL_CYCLES NOP bubbles per
// data hazard, then acks the detector for one cycle. Branch flush overrides everything.
module hazard_stall_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              STALL_CYCLES = 3,
    parameter logic [XLEN-1:0] NOP_INSN     = 32'h00000013,
    parameter int              CNT_W        = 16
) (
    input logic clk,
    input logic rst_n,
    hazard_stall_sequencer_if.slave bus
);

    if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall_cycles
        $error("hazard_stall_sequencer: STALL_CYCLES must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  ex_ir_q, ex_ir_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic             capture;
    logic             bubble;
    logic             count_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            ex_ir_q    <= NOP_INSN;
            ex_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            tot_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_ir_q    <= ex_ir_d;
            ex_pc_q    <= ex_pc_d;
            ex_valid_q <= ex_valid_d;
            tot_q      <= tot_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        bubble       = 1'b0;
        count_bubble = 1'b0;
        if (bus.flush) begin
            // Flush kills the execute slot but is not a hazard bubble.
            bubble  = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.hzd_req) begin
                        bubble       = 1'b1;
                        count_bubble = 1'b1;
                        if (STALL_CYCLES == 1) begin
                            state_d = RELEASE;
                        end else begin
                            cnt_d   = STALL_INIT;
                            state_d = STALL;
                        end
                    end else begin
                        capture = 1'b1;
                    end
                end
                STALL: begin
                    bubble       = 1'b1;
                    count_bubble = 1'b1;
                    if (cnt_q == 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RELEASE: begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        ex_ir_d    = ex_ir_q;
        ex_pc_d    = ex_pc_q;
        ex_valid_d = ex_valid_q;
        if (capture) begin
            ex_ir_d    = bus.dec_ir;
            ex_pc_d    = bus.dec_pc;
            ex_valid_d = bus.dec_valid;
        end else if (bubble) begin
            ex_ir_d    = NOP_INSN;
            ex_valid_d = 1'b0;
        end

        tot_d = tot_q;
        if (count_bubble && (tot_q != {CNT_W{1'b1}})) begin
            tot_d = tot_q + 1'b1;
        end
    end

    // Status is decoded purely from registered state: no input-to-output path.
    always_comb begin
        bus.hzd_ack          = (state_q == RELEASE);
        bus.stall_active     = (state_q != IDLE);
        bus.ex_ir            = ex_ir_q;
        bus.ex_pc            = ex_pc_q;
        bus.ex_valid         = ex_valid_q;
        bus.stall_cycles_tot = tot_q;
        bus.dbg_state        = state_q;
    end

endmodule

// File: tb/tb_hazard_stall_sequencer.sv
// Directed bench: three sequencer instances (3-cycle, 1-cycle, and 3-cycle with a
// 4-bit counter) checked by a scoreboard queue drained by a negedge monitor.
module tb_hazard_stall_sequencer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst_n;

    hazard_stall_sequencer_if #(.XLEN(32), .CNT_W(16)) if_a ();
    hazard_stall_sequencer_if #(.XLEN(32), .CNT_W(16)) if_b ();
    hazard_stall_sequencer_if #(.XLEN(32), .CNT_W(4))  if_c ();

    hazard_stall_sequencer #(.XLEN(32), .STALL_CYCLES(3), .NOP_INSN(NOP), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    hazard_stall_sequencer #(.XLEN(32), .STALL_CYCLES(1), .NOP_INSN(NOP), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    hazard_stall_sequencer #(.XLEN(32), .STALL_CYCLES(3), .NOP_INSN(NOP), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] ir;
        logic [31:0] pc;
        logic        v;
        logic        ack;
        logic        sa;
        logic [15:0] tot;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_vec    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic sample(input logic [1:0] d, output exp_t a);
        a = '0;
        a.dut = d;
        case (d)
            2'd0: begin
                a.ir = if_a.ex_ir; a.pc = if_a.ex_pc; a.v = if_a.ex_valid;
                a.ack = if_a.hzd_ack; a.sa = if_a.stall_active; a.tot = if_a.stall_cycles_tot;
            end
            2'd1: begin
                a.ir = if_b.ex_ir; a.pc = if_b.ex_pc; a.v = if_b.ex_valid;
                a.ack = if_b.hzd_ack; a.sa = if_b.stall_active; a.tot = if_b.stall_cycles_tot;
            end
            default: begin
                a.ir = if_c.ex_ir; a.pc = if_c.ex_pc; a.v = if_c.ex_valid;
                a.ack = if_c.hzd_ack; a.sa = if_c.stall_active;
                a.tot = {12'd0, if_c.stall_cycles_tot};
            end
        endcase
    endtask

    task automatic compare(input string tag, input exp_t a, input exp_t e);
        check({tag, "_ex_ir"},    a.ir,  e.ir);
        check({tag, "_ex_pc"},    a.pc,  e.pc);
        check({tag, "_ex_valid"}, 32'(a.v),   32'(e.v));
        check({tag, "_hzd_ack"},  32'(a.ack), 32'(e.ack));
        check({tag, "_stall_act"}, 32'(a.sa), 32'(e.sa));
        check({tag, "_tot"},      32'(a.tot), 32'(e.tot));
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] d, input logic req, input logic fl,
                         input logic [31:0] ir, input logic [31:0] pc, input logic v);
        case (d)
            2'd0: begin
                if_a.hzd_req = req; if_a.flush = fl; if_a.dec_ir = ir; if_a.dec_pc = pc; if_a.dec_valid = v;
            end
            2'd1: begin
                if_b.hzd_req = req; if_b.flush = fl; if_b.dec_ir = ir; if_b.dec_pc = pc; if_b.dec_valid = v;
            end
            default: begin
                if_c.hzd_req = req; if_c.flush = fl; if_c.dec_ir = ir; if_c.dec_pc = pc; if_c.dec_valid = v;
            end
        endcase
    endtask

    // Drive inputs for the next rising edge and queue the state expected after it.
    task automatic step(input logic [1:0] d, input logic req, input logic fl,
                        input logic [31:0] ir, input logic [31:0] pc, input logic v,
                        input logic [31:0] e_ir, input logic [31:0] e_pc, input logic e_v,
                        input logic e_ack, input logic e_sa, input logic [15:0] e_tot);
        exp_t e;
        @(negedge clk);
        #2;
        drive(d, req, fl, ir, pc, v);
        e.dut = d; e.ir = e_ir; e.pc = e_pc; e.v = e_v;
        e.ack = e_ack; e.sa = e_sa; e.tot = e_tot;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #2;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    endtask

    // scoreboard monitor
    always begin
        exp_t e;
        exp_t a;
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            sample(e.dut, a);
            compare($sformatf("d%0d_v%0d", e.dut, n_vec), a, e);
            n_vec++;
        end
    end

    initial begin
        exp_t e;
        exp_t a;
        logic [31:0] prev_pc;
        logic [31:0] hir;
        logic [31:0] hpc;
        int          k;

        rst_n = 1'b0;
        drive(2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(2'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        e = '0; e.ir = NOP;
        for (int d = 0; d < 3; d++) begin
            sample(2'(d), a);
            e.dut = 2'(d);
            compare($sformatf("reset_d%0d", d), a, e);
        end
        rst_n = 1'b1;

        // T2: plain capture
        step(2'd0, 0, 0, 32'h00A28293, 32'h100, 1, 32'h00A28293, 32'h100, 1, 0, 0, 16'd0);
        // T3: three bubbles, ack on the third, then the held instruction
        step(2'd0, 1, 0, 32'h005302B3, 32'h104, 1, NOP, 32'h100, 0, 0, 1, 16'd1);
        step(2'd0, 1, 0, 32'h005302B3, 32'h104, 1, NOP, 32'h100, 0, 0, 1, 16'd2);
        step(2'd0, 1, 0, 32'h005302B3, 32'h104, 1, NOP, 32'h100, 0, 1, 1, 16'd3);
        step(2'd0, 0, 0, 32'h005302B3, 32'h104, 1, 32'h005302B3, 32'h104, 1, 0, 0, 16'd3);
        step(2'd0, 0, 0, 32'h00000033, 32'h108, 1, 32'h00000033, 32'h108, 1, 0, 0, 16'd3);

        // T1: asynchronous reset while in STALL
        step(2'd0, 1, 0, 32'h00C00113, 32'h10C, 1, NOP, 32'h108, 0, 0, 1, 16'd4);
        wait_drain();
        drive(2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        sample(2'd0, a);
        e = '0; e.ir = NOP;
        compare("async_reset", a, e);
        rst_n = 1'b1;

        // T4: flush on the second stall edge
        step(2'd0, 1, 0, 32'h00B00093, 32'h10C, 1, NOP, 32'h0, 0, 0, 1, 16'd1);
        step(2'd0, 0, 1, 32'h00B00093, 32'h10C, 1, NOP, 32'h0, 0, 0, 0, 16'd1);
        step(2'd0, 0, 0, 32'h00B00093, 32'h10C, 1, 32'h00B00093, 32'h10C, 1, 0, 0, 16'd1);

        // T5: single-cycle stall, back-to-back hazards
        step(2'd1, 1, 0, 32'h00400113, 32'h200, 1, NOP, 32'h0, 0, 1, 1, 16'd1);
        step(2'd1, 1, 0, 32'h00400113, 32'h200, 1, 32'h00400113, 32'h200, 1, 0, 0, 16'd1);
        step(2'd1, 1, 0, 32'h00800193, 32'h204, 1, NOP, 32'h200, 0, 1, 1, 16'd2);
        step(2'd1, 0, 0, 32'h00800193, 32'h204, 1, 32'h00800193, 32'h204, 1, 0, 0, 16'd2);

        // T6: counter saturation at 15 after 18 bubbles
        prev_pc = 32'h0;
        k = 0;
        for (int h = 0; h < 6; h++) begin
            hir = 32'h00100093 + 32'(h);
            hpc = 32'h300 + 32'(4 * h);
            for (int j = 0; j < 3; j++) begin
                k++;
                step(2'd2, 1, 0, hir, hpc, 1, NOP, prev_pc, 0, (j == 2), 1,
                     (k > 15) ? 16'd15 : 16'(k));
            end
            step(2'd2, 0, 0, hir, hpc, 1, hir, hpc, 1, 0, 0, (k > 15) ? 16'd15 : 16'(k));
            prev_pc = hpc;
        end

        wait_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
